// File: rtl/key_expansion_seq.sv
// AES-128 forward key-schedule engine.
// Loads a cipher key and emits round keys 0..10, one per valid/ready handshake.
// The round-10 key is latched as the seed for the decrypt-side inverse schedule.

// Forward AES S-box, one byte lookup.
module key_expansion_sbox (
  input  logic [7:0] a,
  output logic [7:0] q
);

  // Row-major table, entry 0x00 in the top byte.
  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte n sits at bit offset 8*(255-n); 255-n is simply ~n for an 8-bit index.
  assign q = SboxTable[{~a, 3'b000} +: 8];

endmodule

module key_expansion_seq #(
  // Only 10 is legal: the rcon table covers steps 0..9.
  parameter int unsigned ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         ready,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic [127:0] last_key,
  output logic         done
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e         state_q, state_d;
  logic [127:0]   rk_out_q;
  logic [3:0]     rk_round_q;
  logic [127:0]   last_key_q;
  logic           done_q;

  logic           last_round;
  logic           load;
  logic           advance;
  logic           finish;

  logic [31:0]    w0, w1, w2, w3;
  logic [31:0]    rot_word;
  logic [31:0]    sub_word;
  logic [7:0]     rcon_byte;
  logic [31:0]    t_word;
  logic [31:0]    n0, n1, n2, n3;
  logic [127:0]   next_key;

  assign last_round = (rk_round_q == 4'(ROUNDS));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: start only matters in idle; leave run once the last key is taken.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StRun;
      StRun:  if (rk_ready && last_round) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs and datapath strobes decoded from the registered state.
  always_comb begin
    ready    = 1'b0;
    rk_valid = 1'b0;
    load     = 1'b0;
    advance  = 1'b0;
    finish   = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        load  = start;
      end
      StRun: begin
        rk_valid = 1'b1;
        advance  = rk_ready && !last_round;
        finish   = rk_ready && last_round;
      end
      default: ;
    endcase
  end

  // Split the current round key into words and form RotWord(w3).
  always_comb begin
    w0       = rk_out_q[127:96];
    w1       = rk_out_q[95:64];
    w2       = rk_out_q[63:32];
    w3       = rk_out_q[31:0];
    rot_word = {w3[23:0], w3[31:24]};
  end

  // SubWord: one S-box per byte of the rotated word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    key_expansion_sbox u_sbox (
      .a (rot_word[8*gi +: 8]),
      .q (sub_word[8*gi +: 8])
    );
  end

  // Round constant for the step that produces round rk_round+1.
  always_comb begin
    rcon_byte = 8'h00;
    case (rk_round_q)
      4'd0:    rcon_byte = 8'h01;
      4'd1:    rcon_byte = 8'h02;
      4'd2:    rcon_byte = 8'h04;
      4'd3:    rcon_byte = 8'h08;
      4'd4:    rcon_byte = 8'h10;
      4'd5:    rcon_byte = 8'h20;
      4'd6:    rcon_byte = 8'h40;
      4'd7:    rcon_byte = 8'h80;
      4'd8:    rcon_byte = 8'h1b;
      4'd9:    rcon_byte = 8'h36;
      default: rcon_byte = 8'h00;
    endcase
  end

  // Next round key: chained XOR of the previous words with the mixed last word.
  always_comb begin
    t_word   = sub_word ^ {rcon_byte, 24'h000000};
    n0       = w0 ^ t_word;
    n1       = n0 ^ w1;
    n2       = n1 ^ w2;
    n3       = n2 ^ w3;
    next_key = {n0, n1, n2, n3};
  end

  // Round key, index, saved round-10 key and completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rk_out_q   <= '0;
      rk_round_q <= '0;
      last_key_q <= '0;
      done_q     <= 1'b0;
    end else begin
      if (load) begin
        rk_out_q   <= key_in;
        rk_round_q <= 4'd0;
      end else if (advance) begin
        rk_out_q   <= next_key;
        rk_round_q <= rk_round_q + 4'd1;
      end
      // Final key and index are left in place after completion.
      if (finish) begin
        last_key_q <= rk_out_q;
      end
      done_q <= finish;
    end
  end

  assign rk_out   = rk_out_q;
  assign rk_round = rk_round_q;
  assign last_key = last_key_q;
  assign done     = done_q;

endmodule

// File: tb/tb_key_expansion_seq.sv
// Bench for key_expansion_seq: known-answer vectors, backpressure, held start,
// mid-run reset and back-to-back expansions, with a scoreboard of round keys.
module tb_key_expansion_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         ready;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic [127:0] last_key;
  logic         done;

  key_expansion_seq #(.ROUNDS(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .ready    (ready),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_out   (rk_out),
    .rk_round (rk_round),
    .last_key (last_key),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] key;
  } exp_t;

  typedef struct {
    logic [127:0] key;
    logic [127:0] r1;
    logic [127:0] r10;
  } vec_t;

  exp_t         sb[$];
  vec_t         vecs[3];
  logic [7:0]   sbox_tab[256];
  logic [127:0] cap[16];
  int           n_checks = 0;
  int           n_fail = 0;
  int           done_count = 0;
  int           n_accept = 0;
  logic         bp_mode = 1'b0;

  localparam logic [127:0] KeyFips = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R10Fips = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R1Zero  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] R10Zero = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // S-box from the GF(2^8) inverse and affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(a), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_tab[a] = affine(inv);
    end
  endtask

  // Word-recursive key schedule; pushes the 11 expected round keys.
  task automatic push_schedule(input logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    exp_t        e;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]}
            ^ {rc, 24'h000000};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) begin
      e.rnd = 4'(r);
      e.key = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      sb.push_back(e);
    end
  endtask

  // Monitor: score accepted keys, check holds under stall, count done pulses.
  initial begin
    logic         stall_prev = 1'b0;
    logic         done_prev = 1'b0;
    logic [127:0] hold_out = '0;
    logic [3:0]   hold_round = '0;
    exp_t         e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
        done_prev  = 1'b0;
      end else begin
        if (stall_prev && rk_valid) begin
          check("hold rk_out", rk_out, hold_out);
          check("hold rk_round", 128'(rk_round), 128'(hold_round));
        end
        if (rk_valid && rk_ready) begin
          n_accept++;
          cap[rk_round] = rk_out;
          if (sb.size() == 0) begin
            check("unexpected key round", 128'(rk_round), 128'hffff);
          end else begin
            e = sb.pop_front();
            check("round index", 128'(rk_round), 128'(e.rnd));
            check("round key", rk_out, e.key);
          end
        end
        if (done) begin
          done_count++;
          check("done single pulse", 128'(done_prev), 128'(0));
        end
        stall_prev = rk_valid && !rk_ready;
        hold_out   = rk_out;
        hold_round = rk_round;
        done_prev  = done;
      end
    end
  end

  // Pseudo-random backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) rk_ready = 1'($urandom_range(0, 1));
    end
  end

  // Called at posedge+1; the start is taken on the next edge.
  task automatic do_start(input logic [127:0] key);
    check("ready before start", 128'(ready), 128'(1));
    start  = 1'b1;
    key_in = key;
    push_schedule(key);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (!done && cyc < limit) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done timeout: got no done after %0d cycles, expected done", cyc);
    end
  endtask

  initial begin
    int cyc;
    int dc0;
    int acc0;
    int wcnt;

    vecs[0] = '{key: KeyFips, r1: 128'ha0fafe1788542cb123a339392a6c7605, r10: R10Fips};
    vecs[1] = '{key: 128'h0, r1: R1Zero, r10: R10Zero};
    vecs[2] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                r1: 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
                r10: 128'h13111d7fe3944a17f307a78b4d2b30c5};

    build_sbox();
    rst      = 1'b1;
    start    = 1'b0;
    rk_ready = 1'b0;
    key_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", 128'(ready), 128'(1));
    check("reset rk_valid", 128'(rk_valid), 128'(0));
    check("reset rk_out", rk_out, 128'h0);
    check("reset rk_round", 128'(rk_round), 128'(0));
    check("reset last_key", last_key, 128'h0);
    check("reset done", 128'(done), 128'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Known-answer vectors at full rate.
    rk_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      dc0 = done_count;
      do_start(vecs[v].key);
      check("round0 immediately after start", rk_out, vecs[v].key);
      wait_done(40, cyc);
      check("edges from round0 to done", 128'(cyc), 128'(11));
      check("round0 key", cap[0], vecs[v].key);
      check("round1 key", cap[1], vecs[v].r1);
      check("round10 key", cap[10], vecs[v].r10);
      check("last_key", last_key, vecs[v].r10);
      check("ready in done cycle", 128'(ready), 128'(1));
      check("rk_valid in done cycle", 128'(rk_valid), 128'(0));
      check("final rk_round kept", 128'(rk_round), 128'(10));
      check("final rk_out kept", rk_out, vecs[v].r10);
      @(posedge clk);
      #1;
      check("done cleared", 128'(done), 128'(0));
      check("done count", 128'(done_count - dc0), 128'(1));
      check("scoreboard drained", 128'(sb.size()), 128'(0));
    end

    // Backpressure: random rk_ready, keys must hold and stay in order.
    acc0    = n_accept;
    bp_mode = 1'b1;
    do_start(KeyFips);
    wait_done(600, cyc);
    bp_mode  = 1'b0;
    rk_ready = 1'b1;
    check("bp accepted count", 128'(n_accept - acc0), 128'(11));
    check("bp last_key", last_key, R10Fips);
    check("bp scoreboard drained", 128'(sb.size()), 128'(0));
    @(posedge clk);
    #1;

    // start held through the run, then taken again in the done cycle.
    rk_ready = 1'b1;
    check("ready before held start", 128'(ready), 128'(1));
    start  = 1'b1;
    key_in = KeyFips;
    push_schedule(KeyFips);
    @(posedge clk);
    #1;
    key_in = 128'hdeadbeef_0badf00d_12345678_9abcdef0;
    wait_done(40, cyc);
    check("held start last_key", last_key, R10Fips);
    key_in = vecs[2].key;
    push_schedule(vecs[2].key);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("restart round0 key", rk_out, vecs[2].key);
    check("restart round0 index", 128'(rk_round), 128'(0));
    check("restart rk_valid", 128'(rk_valid), 128'(1));
    check("restart ready low", 128'(ready), 128'(0));
    wait_done(40, cyc);
    check("restart last_key", last_key, vecs[2].r10);
    check("restart scoreboard drained", 128'(sb.size()), 128'(0));
    @(posedge clk);
    #1;

    // Reset in the middle of an expansion.
    dc0 = done_count;
    do_start(KeyFips);
    wcnt = 0;
    while (rk_round != 4'd5 && wcnt < 20) begin
      @(posedge clk);
      #1;
      wcnt++;
    end
    check("reached round 5", 128'(rk_round), 128'(5));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    check("mid reset rk_valid", 128'(rk_valid), 128'(0));
    check("mid reset ready", 128'(ready), 128'(1));
    check("mid reset last_key", last_key, 128'h0);
    check("mid reset rk_round", 128'(rk_round), 128'(0));
    check("mid reset done", 128'(done), 128'(0));
    repeat (3) @(posedge clk);
    #1;
    check("no done after reset", 128'(done_count - dc0), 128'(0));
    do_start(KeyFips);
    wait_done(40, cyc);
    check("post reset last_key", last_key, R10Fips);
    check("post reset round1", cap[1], vecs[0].r1);
    check("post reset scoreboard drained", 128'(sb.size()), 128'(0));
    @(posedge clk);
    #1;

    // Back-to-back: FIPS key then zero key.
    do_start(KeyFips);
    wait_done(40, cyc);
    check("b2b first last_key", last_key, R10Fips);
    do_start(128'h0);
    check("b2b last_key kept during second run", last_key, R10Fips);
    wait_done(40, cyc);
    check("b2b second last_key", last_key, R10Zero);
    check("b2b second round1", cap[1], R1Zero);
    check("b2b scoreboard drained", 128'(sb.size()), 128'(0));
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_expansion_seq.md
Name: key_expansion_seq

Overview:
Sequential AES-128 forward key-schedule engine, the encrypt-direction counterpart of the inverse key generator. It loads a 128-bit cipher key and streams round keys 0..10 one per accepted handshake on a valid/ready interface. It also latches the round-10 key as the starting point for the decrypt-side inverse schedule. It sits between key load logic and the round datapath, and instantiates four forward sbox instances for SubWord.

Parameters:
ROUNDS, 10, number of expansion steps after the round-0 key; only 10 is legal (the rcon table covers indices 0..9).

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request expansion; sampled only when ready=1
key_in  input  128  cipher key; sampled on the accepted start edge
ready  output  1  high in IDLE; engine accepts start
rk_valid  output  1  rk_out/rk_round hold a valid round key
rk_ready  input  1  consumer accepts the current round key
rk_out  output  128  current round key, word0 in [127:96]
rk_round  output  4  index of rk_out, 0..10
last_key  output  128  round-10 key of the most recent completed expansion
done  output  1  one-cycle pulse after the round-10 key is accepted

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: state=IDLE, ready=1, rk_valid=0, rk_out=0, rk_round=0, last_key=0, done=0. rst overrides all other inputs on the same edge, including mid-expansion. last_key is cleared by rst.
- States are IDLE and RUN. All outputs are registered; ready=(state==IDLE).
- IDLE: on an edge with start=1, rk_out<=key_in, rk_round<=0, rk_valid<=1, state<=RUN. With start=0, nothing changes.
- RUN: rk_valid=1 throughout. rk_out and rk_round hold stable while rk_ready=0. start is ignored.
- RUN, edge with rk_ready=1 and rk_round<10: rk_out<=next(rk_out, rk_round), rk_round<=rk_round+1.
- RUN, edge with rk_ready=1 and rk_round==10: last_key<=rk_out, done<=1 for exactly one cycle, rk_valid<=0, state<=IDLE. rk_out and rk_round keep their final values.
- A start asserted in the cycle done=1 is accepted, since ready=1 then. The engine supports back-to-back expansions; last_key is overwritten only on the next completion.
- Throughput: with rk_ready tied high, round keys 0..10 appear on 11 consecutive cycles. done follows on cycle 12 after the start edge. Minimum start-to-start period is 12 cycles.
- next(k, i), with words w0..w3 = k[127:96]..k[31:0]:
  - RotWord(w3) = {w3[23:16], w3[15:8], w3[7:0], w3[31:24]}.
  - t = SubWord(RotWord(w3)) ^ rcon(i).
  - n0 = w0^t, n1 = n0^w1, n2 = n1^w2, n3 = n2^w3.
  - rcon(i) = {RC[i], 24'h0}, with RC = 01,02,04,08,10,20,40,80,1b,36 for i = 0..9.
  - The computation is combinational from rk_out and registered into rk_out; there is no extra pipeline stage.
- All arithmetic is GF(2) XOR; there is no carry and no width growth. rk_round never exceeds 10 and never wraps.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse, rk_ready=1 -> round 0 = key; round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; done pulses once; last_key = the round-10 value; ready returns to 1.
- All-zero key -> round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Backpressure: rk_ready toggled pseudo-randomly -> rk_out/rk_round stable while rk_ready=0; exactly 11 accepted keys, in order, matching the FIPS sequence.
- start held high during RUN, then re-asserted in the done cycle -> the mid-run start is ignored; the second expansion begins the next cycle with round 0 = new key_in.
- rst asserted when rk_round=5 -> next cycle rk_valid=0, ready=1, last_key=0, no done pulse; a fresh start then produces the correct full sequence.
- Two back-to-back expansions (FIPS key, then zero key) -> last_key equals d014f9a8... after the first done and b4ef5bcb... after the second.
